// File: rtl/wb_reg_file_2r1w_if.sv
// Bus bundle for the 2-read/1-write register file: two read ports and one write port,
// each with its own strobe/ack/stall handshake.
interface wb_reg_file_2r1w_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  // Read port A
  logic              ra_stb;
  logic [ADDR_W-1:0] ra_addr;
  logic [DATA_W-1:0] ra_data;
  logic              ra_ack;
  logic              ra_stall;
  // Read port B
  logic              rb_stb;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_data;
  logic              rb_ack;
  logic              rb_stall;
  // Write port
  logic              w_stb;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_ack;
  logic              w_stall;

  modport master (
    output ra_stb, ra_addr, rb_stb, rb_addr, w_stb, w_addr, w_data,
    input  ra_data, ra_ack, ra_stall, rb_data, rb_ack, rb_stall, w_ack, w_stall
  );

  modport slave (
    input  ra_stb, ra_addr, rb_stb, rb_addr, w_stb, w_addr, w_data,
    output ra_data, ra_ack, ra_stall, rb_data, rb_ack, rb_stall, w_ack, w_stall
  );
endinterface

// File: rtl/wb_reg_file_2r1w.sv
// Register file with two read ports and one write port, one-cycle latency on each.
// After reset a hardware sweep zeroes every entry; ports stall until it completes.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding on both read ports.
module wb_reg_file_2r1w #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter bit          ZERO_REG0 = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  wb_reg_file_2r1w_if.slave    rf_bus,
  output logic                 o_busy
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic {StClear, StRun} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] mem_q [Depth];

  logic              ra_ack_q, rb_ack_q, w_ack_q;
  logic [DATA_W-1:0] ra_data_q, ra_data_d, rb_data_q, rb_data_d;

  logic              run, ra_acc, rb_acc, w_acc, w_zero;
  logic              ra_zero, rb_zero, ra_fwd, rb_fwd;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign run    = (state_q == StRun);
  assign ra_acc = rf_bus.ra_stb && run;
  assign rb_acc = rf_bus.rb_stb && run;
  assign w_acc  = rf_bus.w_stb && run;

  assign w_zero  = ZERO_REG0 && (rf_bus.w_addr == '0);
  assign ra_zero = ZERO_REG0 && (rf_bus.ra_addr == '0);
  assign rb_zero = ZERO_REG0 && (rf_bus.rb_addr == '0);

`ifdef REGFILE_BYPASS_EN
  assign ra_fwd = w_acc && (rf_bus.w_addr == rf_bus.ra_addr);
  assign rb_fwd = w_acc && (rf_bus.w_addr == rf_bus.rb_addr);
`else
  assign ra_fwd = 1'b0;
  assign rb_fwd = 1'b0;
`endif

  // Sweep sequencing: one entry per cycle, leave the clear state after the last index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StClear) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        state_d = StRun;
      end
    end
  end

  // Single array write port shared by the sweep and the write port; reset blocks both.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = rf_bus.w_addr;
    mem_wdata = rf_bus.w_data;
    if (!i_reset) begin
      if (state_q == StClear) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
      end else if (w_acc && !w_zero) begin
        mem_we = 1'b1;
      end
    end
  end

  // Read data next-state: zero register first, then forwarding, then stored value.
  always_comb begin
    ra_data_d = ra_data_q;
    rb_data_d = rb_data_q;
    if (ra_acc) begin
      if (ra_zero)     ra_data_d = '0;
      else if (ra_fwd) ra_data_d = rf_bus.w_data;
      else             ra_data_d = mem_q[rf_bus.ra_addr];
    end
    if (rb_acc) begin
      if (rb_zero)     rb_data_d = '0;
      else if (rb_fwd) rb_data_d = rf_bus.w_data;
      else             rb_data_d = mem_q[rf_bus.rb_addr];
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StClear;
      cnt_q     <= '0;
      ra_ack_q  <= 1'b0;
      rb_ack_q  <= 1'b0;
      w_ack_q   <= 1'b0;
      ra_data_q <= '0;
      rb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ra_ack_q  <= ra_acc;
      rb_ack_q  <= rb_acc;
      w_ack_q   <= w_acc;
      ra_data_q <= ra_data_d;
      rb_data_q <= rb_data_d;
    end
  end

  // Storage array, no reset: the sweep clears it.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign rf_bus.ra_data  = ra_data_q;
  assign rf_bus.rb_data  = rb_data_q;
  assign rf_bus.ra_ack   = ra_ack_q;
  assign rf_bus.rb_ack   = rb_ack_q;
  assign rf_bus.w_ack    = w_ack_q;
  assign rf_bus.ra_stall = !run;
  assign rf_bus.rb_stall = !run;
  assign rf_bus.w_stall  = !run;
  assign o_busy          = !run;

endmodule

// File: tb/tb_wb_reg_file_2r1w.sv
// Self-checking bench for wb_reg_file_2r1w: directed scenarios plus randomized traffic,
// compared every cycle against a behavioural model of the register file.
module tb_wb_reg_file_2r1w;

  localparam int unsigned DataW = 32;
  localparam int unsigned AddrW = 5;
  localparam int unsigned Depth = 2 ** AddrW;
`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;

  wb_reg_file_2r1w_if #(.DATA_W(DataW), .ADDR_W(AddrW)) bus ();

  wb_reg_file_2r1w #(
    .DATA_W   (DataW),
    .ADDR_W   (AddrW),
    .ZERO_REG0(1'b1)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .rf_bus (bus),
    .o_busy (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [DataW-1:0] ref_mem [Depth];
  bit               m_run;
  int               m_sweep_left;
  logic [DataW-1:0] m_ra_data, m_rb_data;
  bit               m_ra_ack, m_rb_ack, m_w_ack;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DataW-1:0] model_read(input logic [AddrW-1:0] ra, input bit ws,
                                                  input logic [AddrW-1:0] wa,
                                                  input logic [DataW-1:0] wd);
    if (ra == 0) return '0;
    if (Bypass && ws && wa == ra) return wd;
    return ref_mem[ra];
  endfunction

  // One clock: drive inputs, advance the model, then check every output after the edge.
  task automatic cycle(input bit r, input bit as, input logic [AddrW-1:0] aa, input bit bs,
                       input logic [AddrW-1:0] ba, input bit ws, input logic [AddrW-1:0] wa,
                       input logic [DataW-1:0] wd);
    bus.ra_stb = as; bus.ra_addr = aa;
    bus.rb_stb = bs; bus.rb_addr = ba;
    bus.w_stb  = ws; bus.w_addr  = wa; bus.w_data = wd;
    rst = r;
    if (r) begin
      m_run = 0; m_sweep_left = Depth;
      m_ra_ack = 0; m_rb_ack = 0; m_w_ack = 0;
      m_ra_data = '0; m_rb_data = '0;
      for (int i = 0; i < Depth; i++) ref_mem[i] = '0;
    end else if (!m_run) begin
      m_ra_ack = 0; m_rb_ack = 0; m_w_ack = 0;
      m_sweep_left--;
      if (m_sweep_left == 0) m_run = 1;
    end else begin
      m_ra_ack = as; m_rb_ack = bs; m_w_ack = ws;
      if (as) m_ra_data = model_read(aa, ws, wa, wd);
      if (bs) m_rb_data = model_read(ba, ws, wa, wd);
      if (ws && wa != 0) ref_mem[wa] = wd;
    end
    @(posedge clk);
    #1;
    check_eq("ra_ack", 64'(bus.ra_ack), 64'(m_ra_ack));
    check_eq("rb_ack", 64'(bus.rb_ack), 64'(m_rb_ack));
    check_eq("w_ack", 64'(bus.w_ack), 64'(m_w_ack));
    check_eq("ra_data", 64'(bus.ra_data), 64'(m_ra_data));
    check_eq("rb_data", 64'(bus.rb_data), 64'(m_rb_data));
    check_eq("ra_stall", 64'(bus.ra_stall), 64'(!m_run));
    check_eq("rb_stall", 64'(bus.rb_stall), 64'(!m_run));
    check_eq("w_stall", 64'(bus.w_stall), 64'(!m_run));
    check_eq("busy", 64'(busy), 64'(!m_run));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, '0, 0, '0, '0);
  endtask

  task automatic do_reset();
    cycle(1, 0, '0, 0, '0, 0, '0, '0);
  endtask

  initial begin
    bus.ra_stb = 0; bus.ra_addr = '0;
    bus.rb_stb = 0; bus.rb_addr = '0;
    bus.w_stb = 0; bus.w_addr = '0; bus.w_data = '0;
    @(negedge clk);

    // Reset sweep with strobes held high: must be ignored for the whole sweep
    do_reset();
    for (int i = 0; i < Depth; i++) cycle(0, 1, 5'(i), 1, 5'(i), 1, 5'd4, 32'hBAD0_0000);
    check_eq("sweep_done_busy", 64'(busy), 64'd0);
    for (int i = 0; i < Depth; i++) cycle(0, 1, 5'(i), 1, 5'(Depth - 1 - i), 0, '0, '0);
    idle(1);

    // Basic write then read
    cycle(0, 0, '0, 0, '0, 1, 5'd5, 32'hDEADBEEF);
    cycle(0, 1, 5'd5, 0, '0, 0, '0, '0);
    check_eq("basic_rd5", 64'(bus.ra_data), 64'h0000_0000_DEAD_BEEF);

    // Dual read, then both ports on one index
    cycle(0, 0, '0, 0, '0, 1, 5'd3, 32'h11);
    cycle(0, 0, '0, 0, '0, 1, 5'd7, 32'h22);
    cycle(0, 1, 5'd3, 1, 5'd7, 0, '0, '0);
    check_eq("dual_a", 64'(bus.ra_data), 64'h11);
    check_eq("dual_b", 64'(bus.rb_data), 64'h22);
    cycle(0, 1, 5'd7, 1, 5'd7, 0, '0, '0);
    check_eq("same_idx_a", 64'(bus.ra_data), 64'h22);
    check_eq("same_idx_b", 64'(bus.rb_data), 64'h22);

    // Register 0 is hard-wired
    cycle(0, 0, '0, 0, '0, 1, 5'd0, 32'hFFFFFFFF);
    cycle(0, 1, 5'd0, 1, 5'd0, 0, '0, '0);
    check_eq("reg0_a", 64'(bus.ra_data), 64'h0);
    cycle(0, 1, 5'd0, 0, '0, 1, 5'd0, 32'h1234);
    check_eq("reg0_fwd", 64'(bus.ra_data), 64'h0);

    // Collision: write and read of the same index in one cycle
    cycle(0, 0, '0, 0, '0, 1, 5'd9, 32'hAAAA);
    cycle(0, 1, 5'd9, 1, 5'd9, 1, 5'd9, 32'h5555);
    check_eq("collide_a", 64'(bus.ra_data), Bypass ? 64'h5555 : 64'hAAAA);
    cycle(0, 1, 5'd9, 0, '0, 0, '0, '0);
    check_eq("after_collide", 64'(bus.ra_data), 64'h5555);

    // Mid-operation reset drops the pending read ack and restarts the sweep
    cycle(1, 1, 5'd5, 1, 5'd3, 1, 5'd6, 32'h77);
    check_eq("midrst_ack", 64'(bus.ra_ack), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd1);
    idle(Depth);
    cycle(0, 1, 5'd5, 1, 5'd3, 0, '0, '0);
    check_eq("midrst_rd5", 64'(bus.ra_data), 64'h0);

    // Randomized traffic, biased toward a few indices to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      logic [AddrW-1:0] aa, ba, wa;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      aa = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      ba = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wa = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom);
      cycle(($urandom_range(0, 599) == 0), $urandom_range(0, 1) == 1, aa,
            $urandom_range(0, 1) == 1, ba, $urandom_range(0, 1) == 1, wa, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
